// File: rtl/arbiter_rr_if.sv
// Arbiter bus bundle: manager-side requests and subordinate handshakes in,
// request/response grants and FIFO occupancy out.
//   master : drives g_want, req_accepted, resp_accepted; observes grants
//   slave  : the arbiter itself
interface arbiter_rr_if #(
  parameter int unsigned NUM_M           = 2,
  parameter int unsigned MAX_OUTSTANDING = 8
);
  localparam int unsigned G_BITS = $clog2(NUM_M + 1);
  localparam int unsigned C_BITS = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_M-1:0]  g_want;
  logic              req_accepted;
  logic              resp_accepted;
  logic [G_BITS-1:0] g_req;
  logic [G_BITS-1:0] g_resp;
  logic [C_BITS-1:0] outstanding;
  logic              resp_full;

  modport master (
    output g_want, req_accepted, resp_accepted,
    input  g_req, g_resp, outstanding, resp_full
  );

  modport slave (
    input  g_want, req_accepted, resp_accepted,
    output g_req, g_resp, outstanding, resp_full
  );
endinterface

// File: rtl/arbiter_rr.sv
// N-manager to 1-subordinate arbiter with request grant and in-order
// response grant. Round-robin or fixed-priority selection; a grant FIFO
// tracks up to MAX_OUTSTANDING accepted-but-unanswered transactions.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       arbiter_rr_if.slave (g_want, req_accepted, resp_accepted in;
//             g_req, g_resp, outstanding, resp_full out)
module arbiter_rr #(
  parameter int unsigned NUM_M           = 2,
  parameter int unsigned ROUND_ROBIN     = 1,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic         clk,
  input  logic         rst,
  arbiter_rr_if.slave  bus
);
  localparam int unsigned G_BITS = $clog2(NUM_M + 1);
  localparam int unsigned C_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned P_BITS = $clog2(MAX_OUTSTANDING);

  localparam logic [G_BITS-1:0] IDLE    = G_BITS'(NUM_M);
  localparam logic [G_BITS-1:0] LAST_M  = G_BITS'(NUM_M - 1);
  localparam logic [C_BITS-1:0] CNT_MAX = C_BITS'(MAX_OUTSTANDING);

  logic [G_BITS-1:0] g_req_q, g_req_next;
  logic [G_BITS-1:0] rr_ptr, rr_ptr_next;
  logic [C_BITS-1:0] cnt_q, cnt_next;
  logic              full_q;
  logic [P_BITS-1:0] wr_ptr, rd_ptr;
  logic [G_BITS-1:0] mem [MAX_OUTSTANDING];

  logic              push, pop;
  logic [G_BITS-1:0] start;
  logic [G_BITS-1:0] win_hi, win_lo, winner;
  logic              found_hi, found_lo;

  // Winner search: first set bit at or above start, else lowest set bit
  // (the wrap-around part of the rotation). Fixed priority uses start = 0.
  always_comb begin
    start    = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = IDLE;
    win_lo   = IDLE;
    if (ROUND_ROBIN != 0 && rr_ptr != LAST_M) begin
      start = rr_ptr + G_BITS'(1);
    end
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (bus.g_want[i]) begin
        if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = G_BITS'(i);
        end
        if (!found_hi && i >= 32'(start)) begin
          found_hi = 1'b1;
          win_hi   = G_BITS'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  // Next state: FIFO occupancy and request-grant re-arbitration.
  always_comb begin
    push        = bus.req_accepted && (g_req_q != IDLE);
    pop         = bus.resp_accepted && (cnt_q != '0);
    cnt_next    = cnt_q + C_BITS'(push) - C_BITS'(pop);
    g_req_next  = g_req_q;
    rr_ptr_next = rr_ptr;
    if (g_req_q == IDLE || bus.req_accepted) begin
      // A grant is only issued with a free slot, so a held grant never overflows.
      if (cnt_next < CNT_MAX && winner != IDLE) begin
        g_req_next  = winner;
        rr_ptr_next = winner;
      end else begin
        g_req_next  = IDLE;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_req_q <= IDLE;
      rr_ptr  <= LAST_M;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      g_req_q <= g_req_next;
      rr_ptr  <= rr_ptr_next;
      cnt_q   <= cnt_next;
      full_q  <= (cnt_next == CNT_MAX);
      if (push) begin
        wr_ptr <= wr_ptr + P_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + P_BITS'(1);
      end
    end
  end

  // Grant FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= g_req_q;
    end
  end

  assign bus.g_req       = g_req_q;
  assign bus.g_resp      = (cnt_q == '0) ? IDLE : mem[rd_ptr];
  assign bus.outstanding = cnt_q;
  assign bus.resp_full   = full_q;

  // Simulation checks: no overflow, and a held grant stays put.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && cnt_q == CNT_MAX))
        else $error("arbiter_rr: push into full grant FIFO");
      assert (!(g_req_q != IDLE && !bus.req_accepted && g_req_next != g_req_q))
        else $error("arbiter_rr: held request grant changed");
    end
  end
endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench for arbiter_rr: a round-robin and a fixed-priority
// instance share identical stimulus and are compared against a queue-based
// reference model, a directed vector table and a few directed sequences.
module tb_arbiter_rr;
  localparam int NM = 3;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbiter_rr_if #(.NUM_M(NM), .MAX_OUTSTANDING(MO)) if_rr ();
  arbiter_rr_if #(.NUM_M(NM), .MAX_OUTSTANDING(MO)) if_fp ();

  arbiter_rr #(.NUM_M(NM), .ROUND_ROBIN(1), .MAX_OUTSTANDING(MO)) u_rr (
    .clk(clk), .rst(rst), .bus(if_rr)
  );
  arbiter_rr #(.NUM_M(NM), .ROUND_ROBIN(0), .MAX_OUTSTANDING(MO)) u_fp (
    .clk(clk), .rst(rst), .bus(if_fp)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  int m_greq [2];
  int m_last [2];
  int q_rr [$];
  int q_fp [$];

  function automatic int qsize(int p);
    return (p == 0) ? q_rr.size() : q_fp.size();
  endfunction

  function automatic int qhead(int p);
    if (qsize(p) == 0) return NM;
    return (p == 0) ? q_rr[0] : q_fp[0];
  endfunction

  task automatic qpush(int p, int v);
    if (p == 0) q_rr.push_back(v);
    else        q_fp.push_back(v);
  endtask

  task automatic qpop(int p);
    int d;
    if (p == 0) d = q_rr.pop_front();
    else        d = q_fp.pop_front();
  endtask

  // Winner from the policy rules: rotate from last winner, or lowest index.
  function automatic int pick(int p, logic [NM-1:0] want, int last);
    if (p == 0) begin
      for (int d = 1; d <= NM; d++) begin
        int i;
        i = (last + d) % NM;
        if (want[i]) return i;
      end
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (want[i]) return i;
      end
    end
    return NM;
  endfunction

  task automatic model_step(int p, logic r, logic [NM-1:0] w, logic ra, logic sa);
    bit push, pop;
    if (r) begin
      if (p == 0) q_rr.delete();
      else        q_fp.delete();
      m_greq[p] = NM;
      m_last[p] = NM - 1;
      return;
    end
    push = ra && (m_greq[p] != NM);
    pop  = sa && (qsize(p) > 0);
    if (pop)  qpop(p);
    if (push) qpush(p, m_greq[p]);
    if (m_greq[p] == NM || ra) begin
      if (qsize(p) < MO) m_greq[p] = pick(p, w, m_last[p]);
      else               m_greq[p] = NM;
      if (m_greq[p] != NM) m_last[p] = m_greq[p];
    end
  endtask

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
  endtask

  // One clock: drive inputs, step model at the edge, compare #1 later.
  task automatic cycle(logic r, logic [NM-1:0] w, logic ra, logic sa);
    int gq, gr, oc, fl;
    rst = r;
    if_rr.g_want = w; if_rr.req_accepted = ra; if_rr.resp_accepted = sa;
    if_fp.g_want = w; if_fp.req_accepted = ra; if_fp.resp_accepted = sa;
    @(posedge clk);
    model_step(0, r, w, ra, sa);
    model_step(1, r, w, ra, sa);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      gq = (p == 0) ? int'(if_rr.g_req)       : int'(if_fp.g_req);
      gr = (p == 0) ? int'(if_rr.g_resp)      : int'(if_fp.g_resp);
      oc = (p == 0) ? int'(if_rr.outstanding) : int'(if_fp.outstanding);
      fl = (p == 0) ? int'(if_rr.resp_full)   : int'(if_fp.resp_full);
      check(p == 0 ? "rr_g_req"       : "fp_g_req",       gq, m_greq[p]);
      check(p == 0 ? "rr_g_resp"      : "fp_g_resp",      gr, qhead(p));
      check(p == 0 ? "rr_outstanding" : "fp_outstanding", oc, qsize(p));
      check(p == 0 ? "rr_resp_full"   : "fp_resp_full",   fl, (qsize(p) == MO) ? 1 : 0);
    end
  endtask

  typedef struct {
    logic          r;
    logic [NM-1:0] w;
    logic          ra;
    logic          sa;
    int            e_rr_greq;
    int            e_rr_gresp;
    int            e_rr_out;
    int            e_rr_full;
    int            e_fp_greq;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [NM-1:0] w;
    logic          r, ra, sa;
    int            exp_g [3];

    if_rr.g_want = '0; if_rr.req_accepted = 1'b0; if_rr.resp_accepted = 1'b0;
    if_fp.g_want = '0; if_fp.req_accepted = 1'b0; if_fp.resp_accepted = 1'b0;

    //          r     w       ra    sa    rrg rrr rro rrf fpg
    tbl[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 3,  3,  0,  0,  3};
    tbl[1]  = '{1'b0, 3'b001, 1'b0, 1'b0, 0,  3,  0,  0,  0};
    tbl[2]  = '{1'b0, 3'b001, 1'b1, 1'b0, 0,  0,  1,  0,  0};
    tbl[3]  = '{1'b0, 3'b011, 1'b1, 1'b0, 1,  0,  2,  0,  0};
    tbl[4]  = '{1'b0, 3'b011, 1'b1, 1'b0, 0,  0,  3,  0,  0};
    tbl[5]  = '{1'b0, 3'b111, 1'b1, 1'b0, 3,  0,  4,  1,  3};
    tbl[6]  = '{1'b0, 3'b111, 1'b1, 1'b0, 3,  0,  4,  1,  3};
    tbl[7]  = '{1'b0, 3'b111, 1'b0, 1'b1, 1,  0,  3,  0,  0};
    tbl[8]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2,  1,  3,  0,  0};
    tbl[9]  = '{1'b0, 3'b111, 1'b1, 1'b0, 3,  1,  4,  1,  3};
    tbl[10] = '{1'b0, 3'b000, 1'b0, 1'b1, 3,  0,  3,  0,  3};
    tbl[11] = '{1'b1, 3'b000, 1'b0, 1'b0, 3,  3,  0,  0,  3};
    tbl[12] = '{1'b0, 3'b100, 1'b0, 1'b0, 2,  3,  0,  0,  2};
    tbl[13] = '{1'b0, 3'b110, 1'b1, 1'b1, 1,  2,  1,  0,  1};

    for (int k = 0; k < 14; k++) begin
      cycle(tbl[k].r, tbl[k].w, tbl[k].ra, tbl[k].sa);
      check("tbl_rr_g_req",       int'(if_rr.g_req),       tbl[k].e_rr_greq);
      check("tbl_rr_g_resp",      int'(if_rr.g_resp),      tbl[k].e_rr_gresp);
      check("tbl_rr_outstanding", int'(if_rr.outstanding), tbl[k].e_rr_out);
      check("tbl_rr_resp_full",   int'(if_rr.resp_full),   tbl[k].e_rr_full);
      check("tbl_fp_g_req",       int'(if_fp.g_req),       tbl[k].e_fp_greq);
    end

    // Single manager streaming until the FIFO fills.
    cycle(1'b1, 3'b000, 1'b0, 1'b0);
    cycle(1'b0, 3'b001, 1'b0, 1'b0);
    check("single_first_grant", int'(if_rr.g_req), 0);
    for (int k = 1; k <= MO; k++) begin
      cycle(1'b0, 3'b001, 1'b1, 1'b0);
      check("single_outstanding", int'(if_rr.outstanding), k);
      check("single_g_resp", int'(if_rr.g_resp), 0);
    end
    check("single_full", int'(if_rr.resp_full), 1);
    check("single_withheld", int'(if_rr.g_req), NM);
    cycle(1'b0, 3'b001, 1'b0, 1'b1);
    check("single_regrant", int'(if_rr.g_req), 0);

    // Round-robin alternation and in-order response grants.
    cycle(1'b1, 3'b000, 1'b0, 1'b0);
    cycle(1'b0, 3'b011, 1'b0, 1'b0);
    check("alt_first", int'(if_rr.g_req), 0);
    exp_g[0] = 1; exp_g[1] = 0; exp_g[2] = 1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 3'b011, 1'b1, 1'b0);
      check("alt_g_req", int'(if_rr.g_req), exp_g[k]);
    end
    cycle(1'b0, 3'b000, 1'b1, 1'b0);
    check("alt_full", int'(if_rr.resp_full), 1);
    for (int k = 0; k < 4; k++) begin
      check("alt_resp_order", int'(if_rr.g_resp), k % 2);
      cycle(1'b0, 3'b000, 1'b0, 1'b1);
    end
    check("alt_drained", int'(if_rr.g_resp), NM);
    cycle(1'b0, 3'b000, 1'b0, 1'b1);
    check("empty_pop_ignored", int'(if_rr.outstanding), 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      r  = ($urandom_range(0, 99) == 0);
      w  = NM'($urandom_range(0, (1 << NM) - 1));
      ra = ($urandom_range(0, 3) != 0);
      sa = ($urandom_range(0, 2) == 0);
      cycle(r, w, ra, sa);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
